// File: rtl/trap_ctrl_csr_pkg.sv
// Shared types and constants for the machine-mode trap controller and CSR file.
package trap_ctrl_csr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PROGRAM     = 3'd1,
        ST_TRAP_PREP   = 3'd2,
        ST_TRAP_HANDLE = 3'd3,
        ST_FLUSH       = 3'd4,
        ST_DONE        = 3'd5
    } state_t;

    localparam logic [11:0] CSR_MSTATUS    = 12'h300;
    localparam logic [11:0] CSR_MIE        = 12'h304;
    localparam logic [11:0] CSR_MTVEC      = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH   = 12'h340;
    localparam logic [11:0] CSR_MEPC       = 12'h341;
    localparam logic [11:0] CSR_MCAUSE     = 12'h342;
    localparam logic [11:0] CSR_MIP        = 12'h344;
    localparam logic [11:0] CSR_TRAPCNT_LO = 12'hB03;
    localparam logic [11:0] CSR_TRAPCNT_HI = 12'hB83;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    // Wide enough for up to 16 interrupt sources.
    localparam int IRQ_IDX_W = 4;

endpackage

// File: rtl/trap_ctrl_csr_if.sv
// Pipeline-side signal bundle of the trap controller; master drives requests, slave is the controller.
interface trap_ctrl_csr_if #(
    parameter int XLEN    = 32,
    parameter int NUM_IRQ = 4
);
    logic                start_i;
    logic                reset_request_i;
    logic                end_condition_i;
    logic                all_ready_i;
    logic                ready_for_irq_i;
    logic [NUM_IRQ-1:0]  irq_i;
    logic                mret_i;
    logic [XLEN-1:0]     pc_stage2_i;
    logic [XLEN-1:0]     next_pc_i;
    logic                branch_taken_i;
    logic                csr_we_i;
    logic [11:0]         csr_waddr_i;
    logic [XLEN-1:0]     csr_wdata_i;
    logic [11:0]         csr_raddr_i;
    logic [XLEN-1:0]     csr_rdata_o;
    logic                enable_design_o;
    logic                flush_o;
    logic                irq_prep_o;
    logic [XLEN-1:0]     trap_vector_o;
    logic [XLEN-1:0]     mepc_o;
    logic [NUM_IRQ-1:0]  irq_ack_o;
    logic                program_finished_o;

    modport master (
        output start_i, reset_request_i, end_condition_i, all_ready_i, ready_for_irq_i,
               irq_i, mret_i, pc_stage2_i, next_pc_i, branch_taken_i,
               csr_we_i, csr_waddr_i, csr_wdata_i, csr_raddr_i,
        input  csr_rdata_o, enable_design_o, flush_o, irq_prep_o, trap_vector_o,
               mepc_o, irq_ack_o, program_finished_o
    );

    modport slave (
        input  start_i, reset_request_i, end_condition_i, all_ready_i, ready_for_irq_i,
               irq_i, mret_i, pc_stage2_i, next_pc_i, branch_taken_i,
               csr_we_i, csr_waddr_i, csr_wdata_i, csr_raddr_i,
        output csr_rdata_o, enable_design_o, flush_o, irq_prep_o, trap_vector_o,
               mepc_o, irq_ack_o, program_finished_o
    );

endinterface

// File: rtl/trap_ctrl_csr_irq_prio_arbiter.sv
// Fixed-priority interrupt arbiter: the lowest-index pending source wins.
module irq_prio_arbiter
    import trap_ctrl_csr_pkg::*;
#(
    parameter int NUM_IRQ = 4
) (
    input  logic [NUM_IRQ-1:0]   req,
    output logic                 valid,
    output logic [IRQ_IDX_W-1:0] idx
);

    // Scanning downward lets the last hit, i.e. the lowest index, stick.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = i[IRQ_IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/trap_ctrl_csr.sv
// Machine-mode trap controller: run/IRQ FSM, mstatus stacking, mtvec vectoring and CSR port.
// Optional 64-bit trap counter at 0xB03/0xB83 when TRAP_CTRL_TRAP_COUNT_EN is defined.
module trap_ctrl_csr
    import trap_ctrl_csr_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NUM_IRQ    = 4,
    parameter int CAUSE_BASE = 16
) (
    input logic            clk,
    input logic            reset,
    trap_ctrl_csr_if.slave bus
);

    state_t               state_q;
    logic [XLEN-1:0]      mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic                 mstatus_mie_q, mstatus_mpie_q;
    logic [IRQ_IDX_W-1:0] irq_idx_q;
    logic [NUM_IRQ-1:0]   irq_ack_q;

    logic [NUM_IRQ-1:0]   irq_enabled;
    logic                 irq_valid;
    logic [IRQ_IDX_W-1:0] irq_win;
    logic                 trap_enter, mret_take;
    logic [XLEN-1:0]      cause_code, vec_base, trap_vector, mstatus_val, mip_val, rdata;
    logic [XLEN-1:0]      return_pc;

`ifdef TRAP_CTRL_TRAP_COUNT_EN
    logic [63:0]          trap_cnt_q;
`endif

    function automatic logic csr_writable(input logic [11:0] addr);
        case (addr)
            CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE: return 1'b1;
`ifdef TRAP_CTRL_TRAP_COUNT_EN
            CSR_TRAPCNT_LO, CSR_TRAPCNT_HI: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Value a write would leave in the register, used for storage and forwarding alike.
    function automatic logic [XLEN-1:0] csr_wmask(input logic [11:0] addr, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        r = d;
        case (addr)
            CSR_MSTATUS: begin
                r = '0;
                r[MSTATUS_MIE_BIT]  = d[MSTATUS_MIE_BIT];
                r[MSTATUS_MPIE_BIT] = d[MSTATUS_MPIE_BIT];
            end
            CSR_MEPC: r = {d[XLEN-1:2], 2'b00};
`ifdef TRAP_CTRL_TRAP_COUNT_EN
            CSR_TRAPCNT_LO, CSR_TRAPCNT_HI: r = XLEN'(d[31:0]);
`endif
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic wr_hit(input logic we, input logic [11:0] waddr, input logic [11:0] addr);
        return we && (waddr == addr);
    endfunction

    assign irq_enabled = bus.irq_i & mie_q[CAUSE_BASE +: NUM_IRQ];

    irq_prio_arbiter #(
        .NUM_IRQ (NUM_IRQ)
    ) u_arb (
        .req   (irq_enabled),
        .valid (irq_valid),
        .idx   (irq_win)
    );

    assign trap_enter = (state_q == ST_TRAP_PREP) && !bus.reset_request_i && bus.ready_for_irq_i;
    assign mret_take  = (state_q == ST_TRAP_HANDLE) && !bus.reset_request_i && bus.mret_i;

    assign cause_code  = XLEN'(CAUSE_BASE) + XLEN'(irq_idx_q);
    assign vec_base    = {mtvec_q[XLEN-1:2], 2'b00};
    assign trap_vector = (mtvec_q[1:0] == 2'b01) ? vec_base + (cause_code << 2) : vec_base;
    assign return_pc   = bus.branch_taken_i ? bus.next_pc_i : bus.pc_stage2_i + XLEN'(4);

    always_comb begin
        mstatus_val = '0;
        mstatus_val[MSTATUS_MIE_BIT]  = mstatus_mie_q;
        mstatus_val[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
        mip_val = '0;
        mip_val[CAUSE_BASE +: NUM_IRQ] = bus.irq_i;
    end

    always_comb begin
        rdata = '0;
        case (bus.csr_raddr_i)
            CSR_MSTATUS:    rdata = mstatus_val;
            CSR_MIE:        rdata = mie_q;
            CSR_MTVEC:      rdata = mtvec_q;
            CSR_MSCRATCH:   rdata = mscratch_q;
            CSR_MEPC:       rdata = mepc_q;
            CSR_MCAUSE:     rdata = mcause_q;
            CSR_MIP:        rdata = mip_val;
`ifdef TRAP_CTRL_TRAP_COUNT_EN
            CSR_TRAPCNT_LO: rdata = XLEN'(trap_cnt_q[31:0]);
            CSR_TRAPCNT_HI: rdata = XLEN'(trap_cnt_q[63:32]);
`endif
            default:        rdata = '0;
        endcase
        if (bus.csr_we_i && (bus.csr_waddr_i == bus.csr_raddr_i) && csr_writable(bus.csr_raddr_i))
            rdata = csr_wmask(bus.csr_raddr_i, bus.csr_wdata_i);
    end

    // CSR writes come first so the trap-entry / MRET updates below override them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            mie_q          <= '0;
            mtvec_q        <= '0;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            irq_idx_q      <= '0;
            irq_ack_q      <= '0;
        end else begin
            irq_ack_q <= '0;
            if (wr_hit(bus.csr_we_i, bus.csr_waddr_i, CSR_MSTATUS)) begin
                mstatus_mie_q  <= bus.csr_wdata_i[MSTATUS_MIE_BIT];
                mstatus_mpie_q <= bus.csr_wdata_i[MSTATUS_MPIE_BIT];
            end
            if (wr_hit(bus.csr_we_i, bus.csr_waddr_i, CSR_MIE))      mie_q      <= bus.csr_wdata_i;
            if (wr_hit(bus.csr_we_i, bus.csr_waddr_i, CSR_MTVEC))    mtvec_q    <= bus.csr_wdata_i;
            if (wr_hit(bus.csr_we_i, bus.csr_waddr_i, CSR_MSCRATCH)) mscratch_q <= bus.csr_wdata_i;
            if (wr_hit(bus.csr_we_i, bus.csr_waddr_i, CSR_MEPC))
                mepc_q <= csr_wmask(CSR_MEPC, bus.csr_wdata_i);
            if (wr_hit(bus.csr_we_i, bus.csr_waddr_i, CSR_MCAUSE))   mcause_q   <= bus.csr_wdata_i;

            case (state_q)
                ST_IDLE: begin
                    if (bus.start_i) state_q <= ST_PROGRAM;
                end
                ST_PROGRAM: begin
                    if (bus.reset_request_i) begin
                        state_q <= ST_FLUSH;
                    end else if (mstatus_mie_q && irq_valid) begin
                        state_q   <= ST_TRAP_PREP;
                        irq_idx_q <= irq_win;
                    end else if (bus.end_condition_i) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_TRAP_PREP: begin
                    if (bus.reset_request_i) begin
                        state_q <= ST_FLUSH;
                    end else if (trap_enter) begin
                        state_q        <= ST_TRAP_HANDLE;
                        mepc_q         <= {return_pc[XLEN-1:2], 2'b00};
                        mcause_q       <= {1'b1, cause_code[XLEN-2:0]};
                        mstatus_mpie_q <= mstatus_mie_q;
                        mstatus_mie_q  <= 1'b0;
                        irq_ack_q      <= NUM_IRQ'(1) << irq_idx_q;
                    end
                end
                ST_TRAP_HANDLE: begin
                    if (bus.reset_request_i) begin
                        state_q <= ST_FLUSH;
                    end else if (mret_take) begin
                        state_q        <= ST_PROGRAM;
                        mstatus_mie_q  <= mstatus_mpie_q;
                        mstatus_mpie_q <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (bus.all_ready_i) state_q <= ST_IDLE;
                end
                ST_DONE: begin
                    if (bus.reset_request_i) state_q <= ST_FLUSH;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef TRAP_CTRL_TRAP_COUNT_EN
    // A CSR write to either half replaces that half of the incremented value.
    always_ff @(posedge clk) begin
        if (reset) begin
            trap_cnt_q <= '0;
        end else begin
            if (trap_enter) trap_cnt_q <= trap_cnt_q + 64'd1;
            if (wr_hit(bus.csr_we_i, bus.csr_waddr_i, CSR_TRAPCNT_LO))
                trap_cnt_q[31:0]  <= bus.csr_wdata_i[31:0];
            if (wr_hit(bus.csr_we_i, bus.csr_waddr_i, CSR_TRAPCNT_HI))
                trap_cnt_q[63:32] <= bus.csr_wdata_i[31:0];
        end
    end
`endif

    assign bus.csr_rdata_o        = rdata;
    assign bus.enable_design_o    = (state_q != ST_IDLE);
    assign bus.flush_o            = (state_q == ST_FLUSH);
    assign bus.irq_prep_o         = (state_q == ST_TRAP_PREP);
    assign bus.program_finished_o = (state_q == ST_DONE);
    assign bus.trap_vector_o      = trap_vector;
    assign bus.mepc_o             = mepc_q;
    assign bus.irq_ack_o          = irq_ack_q;

endmodule

// File: doc/trap_ctrl_csr.md
Name: trap_ctrl_csr

Overview:
Parametrised machine-mode trap controller and CSR file. It is the next generation of the core's top-level run/IRQ FSM. It arbitrates NUM_IRQ level-sensitive interrupt sources by fixed priority, performs spec-style mstatus MIE/MPIE stacking, and supports direct and vectored mtvec. It sits beside the pipeline, gates enable_design, steers fetch to the handler and back on MRET, and services the CSR stage's read/write port.

Parameters:
XLEN, 32, datapath/CSR width
NUM_IRQ, 4, interrupt source count (1..16)
CAUSE_BASE, 16, mcause code / mie / mip bit of source 0; CAUSE_BASE+NUM_IRQ <= XLEN-1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start_i  in  1  IDLE->PROGRAM request
reset_request_i  in  1  request flush
end_condition_i  in  1  program end detected
all_ready_i  in  1  pipeline drained
ready_for_irq_i  in  1  pipeline ready to redirect
irq_i  in  NUM_IRQ  level interrupt requests
mret_i  in  1  MRET retiring in stage 2
pc_stage2_i  in  XLEN  PC in stage 2
next_pc_i  in  XLEN  branch/jump target
branch_taken_i  in  1  stage-2 redirect valid
csr_we_i  in  1  CSR write strobe
csr_waddr_i  in  12  write address
csr_wdata_i  in  XLEN  write data
csr_raddr_i  in  12  read address
csr_rdata_o  out  XLEN  read data
enable_design_o  out  1  pipeline enable
flush_o  out  1  pipeline flush
irq_prep_o  out  1  trap pending, drain pipeline
trap_vector_o  out  XLEN  handler address
mepc_o  out  XLEN  return address
irq_ack_o  out  NUM_IRQ  one-hot, pulses on trap entry
program_finished_o  out  1  state==DONE

Behaviour:
- Reset: state IDLE; all CSRs 0; all outputs 0, except trap_vector_o=0 and csr_rdata_o=forwarded/0.
- Implemented CSRs: mstatus 0x300 (MIE bit3, MPIE bit7, other bits read 0), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341 (bits[1:0] forced 0), mcause 0x342, mip 0x344. mip is read-only and equals irq_i placed at bits CAUSE_BASE.. with other bits 0. Unimplemented addresses read 0; writes to them are ignored.
- Read: combinational. If csr_we_i and csr_waddr_i==csr_raddr_i, csr_wdata_i is forwarded (masked to implemented bits).
- enabled = irq_i & mie[CAUSE_BASE+:NUM_IRQ]. Winner = lowest index set bit.
- States: IDLE, PROGRAM, TRAP_PREP, TRAP_HANDLE, FLUSH, DONE.
  - IDLE -> PROGRAM on start_i.
  - PROGRAM: reset_request_i -> FLUSH; else (mstatus.MIE && enabled!=0) -> TRAP_PREP, latching the winner index; else end_condition_i -> DONE.
  - TRAP_PREP: reset_request_i -> FLUSH; else ready_for_irq_i -> TRAP_HANDLE. On that edge:
    - mepc = branch_taken_i ? next_pc_i : pc_stage2_i+4
    - mcause = {1'b1, CAUSE_BASE+idx}
    - MPIE = MIE, MIE = 0
    - irq_ack_o[idx] pulses 1 cycle.
  - TRAP_HANDLE: reset_request_i -> FLUSH; mret_i -> PROGRAM with MIE = MPIE, MPIE = 1.
  - FLUSH: flush_o=1; all_ready_i -> IDLE.
  - DONE: reset_request_i -> FLUSH.
  - Illegal encodings -> IDLE.
- The winner is latched in TRAP_PREP. A source dropping before ready does not cancel the trap; the latched cause is used.
- trap_vector_o = mtvec.mode==1 ? base + 4*mcause[4:0]... computed from the latched cause as {base,2'b00} + (CAUSE_BASE+idx)<<2. Mode 0, 2 or 3 gives {base,2'b00}. The value is valid from TRAP_PREP onward.
- Outputs:
  - enable_design_o = state!=IDLE
  - irq_prep_o = state==TRAP_PREP
- Simultaneous events:
  - A trap-entry or MRET hardware update of mstatus/mepc/mcause overrides a same-cycle CSR write to the same CSR. Writes to other CSRs proceed.
  - reset_request_i beats IRQ, which beats end_condition_i.
  - An mret_i seen outside TRAP_HANDLE is ignored by the FSM.
  - reset mid-trap: everything returns to reset values next cycle.
- Arithmetic: pc+4 wraps modulo 2^XLEN.

Optional Feature:
TRAP_CTRL_TRAP_COUNT_EN:
- Defined: adds a 64-bit trap counter, readable at 0xB03 (low) and 0xB83 (high). It increments on every trap entry, wraps to 0, is writable via the CSR port (write wins over increment), and is cleared by reset.
- Undefined: both addresses read 0 and no counter logic exists.

Decomposition:
- Shared package: the state localparams, the CSR address constants (0x300, 0x304, 0x305, 0x340, 0x341, 0x342, 0x344, 0xB03, 0xB83), and the MIE/MPIE bit positions.
- One natural sub-module: irq_prio_arbiter (NUM_IRQ-wide lowest-index priority encoder producing a valid flag and an index).

Test Plan:
1. reset, start_i=1, end_condition_i=1 -> IDLE, PROGRAM, DONE; program_finished_o=1. reset_request_i then all_ready_i -> FLUSH (flush_o=1), then IDLE.
2. mtvec=0x100 (mode 0), mie bit17, MIE=1, irq_i=4'b0010, pc_stage2=0x40, ready -> mepc=0x44, mcause=0x80000011, trap_vector=0x100, MIE=0, MPIE=1, irq_ack_o=0010 for 1 cycle.
3. mtvec=0x101 (vectored), irq_i=4'b1100 -> source 2 wins; mcause=0x80000012, trap_vector=0x148. mret_i -> PROGRAM, MIE=1.
4. branch_taken_i=1, next_pc=0x200 at trap entry -> mepc=0x200. A same-cycle CSR write of 0x7 to mepc is discarded.
5. CSR write 0x300 <- 0x8 with read of 0x300 in the same cycle -> csr_rdata_o=0x8. Read of 0x344 with irq_i=0001 -> 0x00010000.
6. reset_request_i asserted in TRAP_HANDLE -> FLUSH. With TRAP_CTRL_TRAP_COUNT_EN defined, after 3 traps 0xB03 reads 3.
